mem_port_ctrl: RTL

Initiator-side controller for the single-port data RAM (20-bit data, 12-bit word address, registered read, `str`/`ld` strobes). It accepts load/store burst requests from the CPU datapath over valid/ready handshakes and sequences the RAM's `address`, `data_in`, `str` and `ld` pins. It returns load data beat by beat and pulses `done` when a burst completes. It sits between the execute stage and the RAM, and is the only agent that drives the RAM's control pins.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_port_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared widths, FSM encoding and address helper for the data-RAM port
package mem_pkg;

    localparam int DATA_WIDTH = 20;
    localparam int ADDR_WIDTH = 12;
    localparam int LEN_WIDTH  = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WR       = 3'd1;
    localparam logic [2:0] ST_WR_LAST  = 3'd2;
    localparam logic [2:0] ST_RD_ISSUE = 3'd3;
    localparam logic [2:0] ST_RD_DATA  = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        WR       = ST_WR,
        WR_LAST  = ST_WR_LAST,
        RD_ISSUE = ST_RD_ISSUE,
        RD_DATA  = ST_RD_DATA
    } state_e;

    // Word address increment; wraps silently at the top of the RAM.
    function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
        return a + ADDR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - load/store burst sequencer driving the single-port data RAM
module mem_port_ctrl
    import mem_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_str,
    output logic                  mem_ld,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_str_q, mem_str_d;
    logic                  done_q, done_d;

    logic req_hs;
    logic wr_hs;
    logic rd_hs;
    logic cnt_zero;

    // req_ready is gated by rst_n so it reads 0 for the whole reset window.
    assign req_ready = rst_n && (state_q == IDLE);
    assign wr_ready  = (state_q == WR);
    assign rd_valid  = (state_q == RD_DATA);
    assign mem_ld    = (state_q == RD_ISSUE);

    assign cnt_zero  = (cnt_q == '0);
    assign rd_last   = rd_valid && cnt_zero;
    assign rd_data   = mem_rdata;

    assign req_hs    = req_valid && req_ready;
    assign wr_hs     = wr_valid && wr_ready;
    assign rd_hs     = rd_valid && rd_ready;

    // Store beats use the registered address; a read issue presents cur_addr directly.
    assign mem_addr  = mem_ld ? cur_addr_q : mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_str   = mem_str_q;
    assign done      = done_q;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        mem_addr_d  = mem_addr_q;
        cnt_d       = cnt_q;
        mem_wdata_d = mem_wdata_q;
        mem_str_d   = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_hs) begin
                    cur_addr_d = req_addr;
                    cnt_d      = req_len;
                    state_d    = req_write ? WR : RD_ISSUE;
                end
            end

            WR: begin
                if (wr_hs) begin
                    mem_addr_d  = cur_addr_q;
                    mem_wdata_d = wr_data;
                    mem_str_d   = 1'b1;
                    cur_addr_d  = addr_inc(cur_addr_q);
                    if (cnt_zero) begin
                        state_d = WR_LAST;
                    end else begin
                        cnt_d = cnt_q - LEN_WIDTH'(1);
                    end
                end
            end

            // The final beat's strobe is already high; this edge commits it.
            WR_LAST: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            RD_ISSUE: begin
                state_d = RD_DATA;
            end

            RD_DATA: begin
                if (rd_hs) begin
                    if (cnt_zero) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d      = cnt_q - LEN_WIDTH'(1);
                        cur_addr_d = addr_inc(cur_addr_q);
                        state_d    = RD_ISSUE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            mem_addr_q  <= '0;
            cnt_q       <= '0;
            mem_wdata_q <= '0;
            mem_str_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            mem_addr_q  <= mem_addr_d;
            cnt_q       <= cnt_d;
            mem_wdata_q <= mem_wdata_d;
            mem_str_q   <= mem_str_d;
            done_q      <= done_d;
        end
    end

endmodule
